// File: rtl/serial_byte_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_byte_collector_pkg
// Description : Shared project definitions for the serial byte collector:
//               FSM state encodings, bit-position constants and the bit
//               insertion helper used to assemble a byte from serial bits.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_byte_collector_pkg;

    // Collector FSM states. COLLECT gathers bits, HOLD presents a full byte.
    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    // Bit index of the final bit of a byte (bit_count value that completes it).
    localparam logic [2:0] c_last_bit = 3'd7;

    // Inserts one serial bit into the partial byte.
    // LSB-first: bits enter at [7] and move right, so after eight bits the
    // first one has reached [0]. MSB-first: bits enter at [0] and move left,
    // so the first one ends at [7].
    function automatic logic [7:0] shift_in(
        input logic [7:0] cur,
        input logic       b,
        input logic       msb_first
    );
        logic [7:0] res;
        if (msb_first) begin
            res = {cur[6:0], b};
        end else begin
            res = {b, cur[7:1]};
        end
        return res;
    endfunction

endpackage : serial_byte_collector_pkg
`default_nettype wire

// File: rtl/serial_byte_collector_or8.sv
`default_nettype none
// ============================================================================
// Module      : serial_byte_collector_or8
// Description : 8-input OR reduction gate.
// Ports       : din  [7:0] in  - operand bits
//               dout       out - OR of all din bits
// Revision    : 1.0 - initial release
// ============================================================================
module serial_byte_collector_or8 (
    input  logic [7:0] din,
    output logic       dout
);

    assign dout = |din;

endmodule : serial_byte_collector_or8
`default_nettype wire

// File: rtl/serial_byte_collector.sv
`default_nettype none
// ============================================================================
// Module      : serial_byte_collector
// Description : Collects a stream of valid/ready serial bits into bytes and
//               presents each completed byte on a valid/ready output until
//               the consumer takes it. A synchronous flush discards a
//               partially collected byte without touching the held byte.
// Parameters  : MSB_FIRST - 0: first bit lands in byte_out[0]
//                           1: first bit lands in byte_out[7]
// Ports       : clk        in   clock, rising edge
//               rst_n      in   asynchronous active-low reset
//               bit_in     in   serial data bit
//               bit_valid  in   bit_in valid this cycle
//               bit_ready  out  a bit is accepted this cycle (combinational)
//               flush      in   abort the partial byte
//               byte_out   out  assembled byte (registered)
//               byte_valid out  byte_out holds an undelivered byte
//               out_ready  in   consumer takes byte_out this cycle
//               any_set    out  OR of byte_out bits
//               bit_count  out  bits collected toward the current byte
// Revision    : 1.0 - initial release
// ============================================================================
module serial_byte_collector
    import serial_byte_collector_pkg::*;
#(
    parameter int MSB_FIRST = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    input  logic       flush,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       out_ready,
    output logic       any_set,
    output logic [2:0] bit_count
);

    state_t     r_state;
    logic [7:0] r_shift;
    logic [2:0] r_count;
    logic [7:0] r_byte;

    state_t     w_state_nxt;
    logic [7:0] w_shift_nxt;
    logic [2:0] w_count_nxt;
    logic [7:0] w_byte_nxt;

    logic       w_accept;
    logic       w_handover;
    logic [7:0] w_shifted;

    // In HOLD a bit may only enter in the cycle the held byte is taken, which
    // keeps one byte per eight bit-cycles under continuous streaming.
    assign bit_ready  = !flush && ((r_state == COLLECT) || out_ready);
    assign w_accept   = bit_valid && bit_ready;
    assign w_handover = (r_state == HOLD) && out_ready;
    assign w_shifted  = shift_in(r_shift, bit_in, MSB_FIRST != 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= COLLECT;
            r_shift <= 8'h00;
            r_count <= 3'd0;
            r_byte  <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_count <= w_count_nxt;
            r_byte  <= w_byte_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_count_nxt = r_count;
        w_byte_nxt  = r_byte;

        // Consumer handover is independent of flush: flush only aborts the
        // partial byte, never the held one.
        if (w_handover) begin
            w_state_nxt = COLLECT;
        end

        if (flush) begin
            w_shift_nxt = 8'h00;
            w_count_nxt = 3'd0;
        end else if (w_accept) begin
            if (r_count == c_last_bit) begin
                w_byte_nxt  = w_shifted;
                w_shift_nxt = 8'h00;
                w_count_nxt = 3'd0;
                w_state_nxt = HOLD;
            end else begin
                w_shift_nxt = w_shifted;
                w_count_nxt = r_count + 3'd1;
            end
        end
    end

    assign byte_out   = r_byte;
    assign byte_valid = (r_state == HOLD);
    assign bit_count  = r_count;

    serial_byte_collector_or8 u_or8 (
        .din  (r_byte),
        .dout (any_set)
    );

endmodule : serial_byte_collector
`default_nettype wire
